seq_multiplier: RTL and testbench

SEQ_MULTIPLIER -- requirements
Module: seq_multiplier

---
 rtl/mult_pkg.sv | 16 +
 rtl/mult_step.sv | 27 ++
 rtl/seq_multiplier.sv | 141 ++++++++++++++
 tb/tb_seq_multiplier.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared definitions for the sequential multiplier and the blocks that track its timing.
//   - FSM state encoding (2 bits)
//   - mult_latency(): edges from the accept edge until hi/lo and done become valid.
package mult_pkg;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRun  = 2'd1;
  localparam logic [1:0] StFix  = 2'd2;

  // One RUN cycle per UNROLL multiplier bits, plus the FIX (sign/load) cycle.
  function automatic int unsigned mult_latency(input int unsigned width,
                                               input int unsigned unroll);
    return width / unroll + 1;
  endfunction

endpackage

// File: rtl/mult_step.sv
// One cycle of shift-add multiplication: adds up to UNROLL shifted copies of the multiplicand
// into the accumulator, one per set bit of the multiplier slice. Purely combinational.
// Ports:
//   acc      - current 2*WIDTH accumulator
//   mcand    - multiplicand, already aligned to this cycle's bit position
//   mbits    - the UNROLL low multiplier bits retired this cycle
//   acc_next - accumulator after this cycle's partial products
module mult_step #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned UNROLL = 1
) (
  input  logic [2*WIDTH-1:0] acc,
  input  logic [2*WIDTH-1:0] mcand,
  input  logic [UNROLL-1:0]  mbits,
  output logic [2*WIDTH-1:0] acc_next
);

  always_comb begin
    acc_next = acc;
    for (int i = 0; i < UNROLL; i++) begin
      if (mbits[i]) begin
        acc_next = acc_next + (mcand << i);
      end
    end
  end

endmodule

// File: rtl/seq_multiplier.sv
// Iterative signed/unsigned multiplier retiring UNROLL multiplier bits per cycle.
// Operates on magnitudes and fixes the sign in a final cycle.
// Ports:
//   clk        - clock, all state on rising edge
//   reset      - synchronous active-low reset
//   start_mult - request a multiply of srca*srcb (accepted only when idle)
//   mult_sign  - 1: two's-complement operands, 0: unsigned; sampled with start_mult
//   flush      - kill the in-flight operation (or a same-cycle request)
//   srca, srcb - multiplicand / multiplier, sampled only on the accept edge
//   hi, lo     - upper / lower half of the last completed product
//   busy       - operation in flight (RUN or FIX)
//   done       - one-cycle pulse when hi/lo update
module seq_multiplier
  import mult_pkg::*;
#(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned UNROLL = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_mult,
  input  logic             mult_sign,
  input  logic             flush,
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done
);

  localparam int unsigned Steps = mult_latency(WIDTH, UNROLL) - 1;
  localparam int unsigned CntW  = $clog2(Steps + 1);

  if (WIDTH < 8 || WIDTH > 64 || (WIDTH % 2) != 0 ||
      (UNROLL != 1 && UNROLL != 2 && UNROLL != 4) || (WIDTH % UNROLL) != 0) begin : g_bad_params
    $error("seq_multiplier: illegal WIDTH/UNROLL combination");
  end

  logic [1:0]         state_q, state_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic               neg_q, neg_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;

  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [2*WIDTH-1:0] acc_step;

  // Unsigned negation also yields the right magnitude for the most-negative value.
  assign mag_a = (mult_sign && srca[WIDTH-1]) ? -srca : srca;
  assign mag_b = (mult_sign && srcb[WIDTH-1]) ? -srcb : srcb;

  mult_step #(
    .WIDTH  (WIDTH),
    .UNROLL (UNROLL)
  ) u_step (
    .acc      (acc_q),
    .mcand    (mcand_q),
    .mbits    (mplier_q[UNROLL-1:0]),
    .acc_next (acc_step)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    neg_d    = neg_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start_mult && !flush) begin
          state_d  = StRun;
          mcand_d  = {{WIDTH{1'b0}}, mag_a};
          mplier_d = mag_b;
          neg_d    = mult_sign & (srca[WIDTH-1] ^ srcb[WIDTH-1]);
          cnt_d    = CntW'(Steps);
          acc_d    = '0;
        end
      end
      StRun: begin
        if (flush) begin
          state_d = StIdle;
        end else begin
          acc_d    = acc_step;
          mcand_d  = mcand_q << UNROLL;
          mplier_d = mplier_q >> UNROLL;
          cnt_d    = cnt_q - CntW'(1);
          if (cnt_q == CntW'(1)) begin
            state_d = StFix;
          end
        end
      end
      StFix: begin
        state_d = StIdle;
        if (!flush) begin
          {hi_d, lo_d} = neg_q ? -acc_q : acc_q;
          done_d       = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      neg_q    <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      neg_q    <= neg_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
    end
  end

  assign hi   = hi_q;
  assign lo   = lo_q;
  assign done = done_q;
  assign busy = (state_q == StRun) || (state_q == StFix);

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed bench for seq_multiplier: a 32/1 instance for function, flush, reset and
// back-to-back behaviour, and a 32/4 instance for the unrolled latency.
module tb_seq_multiplier;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  logic        s1_start, s1_sign, s1_flush;
  logic [31:0] s1_a, s1_b, u1_hi, u1_lo;
  logic        u1_busy, u1_done;

  logic        s4_start, s4_sign, s4_flush;
  logic [31:0] s4_a, s4_b, u4_hi, u4_lo;
  logic        u4_busy, u4_done;

  seq_multiplier #(.WIDTH(32), .UNROLL(1)) u_dut1 (
    .clk        (clk),
    .reset      (reset),
    .start_mult (s1_start),
    .mult_sign  (s1_sign),
    .flush      (s1_flush),
    .srca       (s1_a),
    .srcb       (s1_b),
    .hi         (u1_hi),
    .lo         (u1_lo),
    .busy       (u1_busy),
    .done       (u1_done)
  );

  seq_multiplier #(.WIDTH(32), .UNROLL(4)) u_dut4 (
    .clk        (clk),
    .reset      (reset),
    .start_mult (s4_start),
    .mult_sign  (s4_sign),
    .flush      (s4_flush),
    .srca       (s4_a),
    .srcb       (s4_b),
    .hi         (u4_hi),
    .lo         (u4_lo),
    .busy       (u4_busy),
    .done       (u4_done)
  );

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  logic [63:0] q1[$];
  logic [63:0] q4[$];
  logic [63:0] last1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic sgn);
    longint sa, sb;
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      return 64'(sa * sb);
    end
    return {32'b0, a} * {32'b0, b};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives a one-cycle request, then scrambles the operand inputs after the accept edge.
  task automatic issue(input bit sel4, input logic [31:0] a, input logic [31:0] b,
                       input logic sgn, input logic [63:0] exp, input bit push);
    if (sel4) begin
      s4_a = a; s4_b = b; s4_sign = sgn; s4_start = 1'b1;
      if (push) q4.push_back(exp);
    end else begin
      s1_a = a; s1_b = b; s1_sign = sgn; s1_start = 1'b1;
      if (push) q1.push_back(exp);
    end
    tick();
    s1_start = 1'b0;
    s4_start = 1'b0;
    if (sel4) begin
      s4_a = $urandom; s4_b = $urandom; s4_sign = 1'($urandom);
    end else begin
      s1_a = $urandom; s1_b = $urandom; s1_sign = 1'($urandom);
    end
  endtask

  // c0/bc0: cycles and busy samples already consumed by the caller since the accept edge.
  task automatic wait_done(input bit sel4, input int exp_lat, input string tag,
                           input int c0, input int bc0);
    int c;
    int bc;
    bit seen;
    logic [63:0] exp;
    c    = c0;
    bc   = bc0 + ((sel4 ? u4_busy : u1_busy) ? 1 : 0);
    seen = 1'b0;
    while (!seen && c < 200) begin
      tick();
      c++;
      if (sel4 ? u4_done : u1_done) seen = 1'b1;
      else if (sel4 ? u4_busy : u1_busy) bc++;
    end
    check({tag, "_done_seen"}, 64'(seen), 64'd1);
    if (seen) begin
      check({tag, "_latency"}, 64'(c), 64'(exp_lat));
      check({tag, "_busy_cycles"}, 64'(bc), 64'(exp_lat));
      check({tag, "_busy_in_done"}, 64'(sel4 ? u4_busy : u1_busy), 64'd0);
      if ((sel4 ? q4.size() : q1.size()) == 0) begin
        check({tag, "_sb_nonempty"}, 64'd0, 64'd1);
      end else begin
        exp = sel4 ? q4.pop_front() : q1.pop_front();
        check({tag, "_product"}, sel4 ? {u4_hi, u4_lo} : {u1_hi, u1_lo}, exp);
        if (!sel4) last1 = {u1_hi, u1_lo};
      end
    end
  endtask

  task automatic count_dones(input int n, output int dones);
    dones = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (u1_done) dones++;
    end
  endtask

  initial begin
    int dones;
    int bc;
    logic [31:0] ra, rb;
    logic        rs;

    reset = 1'b0;
    s1_start = 0; s1_sign = 0; s1_flush = 0; s1_a = 0; s1_b = 0;
    s4_start = 0; s4_sign = 0; s4_flush = 0; s4_a = 0; s4_b = 0;
    last1 = '0;
    repeat (3) tick();
    check("reset_hilo1", {u1_hi, u1_lo}, 64'd0);
    check("reset_busy1", 64'(u1_busy), 64'd0);
    check("reset_done1", 64'(u1_done), 64'd0);
    check("reset_hilo4", {u4_hi, u4_lo}, 64'd0);
    check("reset_bd4", {62'd0, u4_busy, u4_done}, 64'd0);
    reset = 1'b1;
    tick();

    // Spec vectors, 32/1
    issue(0, 32'd7, 32'd6, 1'b0, 64'h00000000_0000002A, 1);
    wait_done(0, 33, "u7x6", 0, 0);
    tick();
    check("done_single_pulse", 64'(u1_done), 64'd0);
    issue(0, 32'hFFFFFFFD, 32'd5, 1'b1, 64'hFFFFFFFF_FFFFFFF1, 1);
    wait_done(0, 33, "s_m3x5", 0, 0);
    issue(0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 64'hFFFFFFFE_00000001, 1);
    wait_done(0, 33, "u_ffxff", 0, 0);
    issue(0, 32'h80000000, 32'h80000000, 1'b1, 64'h40000000_00000000, 1);
    wait_done(0, 33, "s_minxmin", 0, 0);
    issue(0, 32'h80000000, 32'hFFFFFFFF, 1'b1, 64'h00000000_80000000, 1);
    wait_done(0, 33, "s_minxm1", 0, 0);

    // Hold between completions
    repeat (5) tick();
    check("hold_hilo", {u1_hi, u1_lo}, last1);

    // Flush 10 cycles after accept
    issue(0, 32'h1234, 32'h5678, 1'b0, 64'd0, 0);
    repeat (9) tick();
    s1_flush = 1'b1;
    tick();
    s1_flush = 1'b0;
    check("flush_busy", 64'(u1_busy), 64'd0);
    count_dones(40, dones);
    check("flush_no_done", 64'(dones), 64'd0);
    check("flush_hilo_kept", {u1_hi, u1_lo}, last1);

    // start_mult during a run is ignored
    issue(0, 32'hDEAD, 32'hBEEF, 1'b0, model(32'hDEAD, 32'hBEEF, 1'b0), 1);
    bc = 0;
    repeat (4) begin
      if (u1_busy) bc++;
      tick();
    end
    s1_start = 1'b1; s1_a = 32'd3; s1_b = 32'd3;
    if (u1_busy) bc++;
    tick();
    s1_start = 1'b0;
    wait_done(0, 33, "ignore_start", 5, bc);
    count_dones(40, dones);
    check("ignore_single_done", 64'(dones), 64'd0);

    // Back-to-back: second request in the done cycle
    issue(0, 32'd1000, 32'd1001, 1'b0, model(32'd1000, 32'd1001, 1'b0), 1);
    wait_done(0, 33, "b2b_first", 0, 0);
    issue(0, 32'hFFFF0000, 32'd77, 1'b1, model(32'hFFFF0000, 32'd77, 1'b1), 1);
    wait_done(0, 33, "b2b_second", 0, 0);

    // flush with start in IDLE drops the request
    s1_start = 1'b1; s1_flush = 1'b1; s1_a = 32'd9; s1_b = 32'd9;
    tick();
    s1_start = 1'b0; s1_flush = 1'b0;
    check("idle_flush_busy", 64'(u1_busy), 64'd0);
    count_dones(40, dones);
    check("idle_flush_no_done", 64'(dones), 64'd0);
    check("idle_flush_hilo", {u1_hi, u1_lo}, last1);

    // Random operands, alternating mode
    for (int i = 0; i < 4; i++) begin
      ra = $urandom; rb = $urandom; rs = 1'(i);
      issue(0, ra, rb, rs, model(ra, rb, rs), 1);
      wait_done(0, 33, "rand", 0, 0);
    end

    // UNROLL=4
    issue(1, 32'h12345678, 32'h9ABCDEF0, 1'b0, 64'h0B00EA4E_242D2080, 1);
    wait_done(1, 9, "u4_vec", 0, 0);
    ra = $urandom; rb = $urandom;
    issue(1, ra, rb, 1'b1, model(ra, rb, 1'b1), 1);
    wait_done(1, 9, "u4_rand_signed", 0, 0);

    // Reset mid-RUN, with a start request that must be ignored
    issue(0, 32'hABCD, 32'h1234, 1'b0, 64'd0, 0);
    repeat (9) tick();
    reset = 1'b0;
    s1_start = 1'b1; s1_a = 32'd5; s1_b = 32'd5;
    tick();
    check("rst_mid_hilo1", {u1_hi, u1_lo}, 64'd0);
    check("rst_mid_busy", 64'(u1_busy), 64'd0);
    check("rst_mid_done", 64'(u1_done), 64'd0);
    check("rst_mid_hilo4", {u4_hi, u4_lo}, 64'd0);
    reset = 1'b1;
    s1_start = 1'b0;
    tick();
    check("rst_start_ignored", 64'(u1_busy), 64'd0);
    count_dones(40, dones);
    check("rst_no_done", 64'(dones), 64'd0);

    check("sb_empty1", 64'(q1.size()), 64'd0);
    check("sb_empty4", 64'(q4.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
